// File: rtl/seq_mul_16bit_pkg.sv
// Shared definitions for the Zilla ALU sequential multiplier: FSM state encodings and widths.
package seq_mul_16bit_pkg;

  localparam int unsigned MulW    = 16;
  localparam int unsigned MulCntW = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/cla_adder_16bit.sv
// 16-bit carry-lookahead adder: four 4-bit lookahead groups with a second-level group lookahead.
module cla_adder_16bit (
  input  logic [15:0] ain,
  input  logic [15:0] bin,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [15:0] g;
  logic [15:0] p;
  logic [16:0] c;
  logic [3:0]  gg;
  logic [3:0]  pg;

  always_comb begin
    g  = ain & bin;
    p  = ain ^ bin;
    c  = '0;
    gg = '0;
    pg = '0;
    c[0] = cin;
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1]) |
              (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      pg[k] = &p[4*k +: 4];
    end
    // Group carries come straight from group generate/propagate, not from a ripple chain.
    c[4]  = gg[0] | (pg[0] & c[0]);
    c[8]  = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & c[0]);
    c[12] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0]) | (pg[2] & pg[1] & pg[0] & c[0]);
    c[16] = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1]) | (pg[3] & pg[2] & pg[1] & gg[0]) |
            (pg[3] & pg[2] & pg[1] & pg[0] & c[0]);
    for (int k = 0; k < 4; k++) begin
      c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k]) |
                 (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
    end
    sum  = p ^ c[15:0];
    cout = c[16];
  end

endmodule

// File: rtl/seq_mul_16bit.sv
// Iterative shift-add multiplier producing the low 16 bits of ain*bin, one partial-product
// add per cycle through a CLA, with valid/ready handshakes on operands and result.
module seq_mul_16bit
  import seq_mul_16bit_pkg::*;
#(
  parameter bit EARLY_TERM = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [MulW-1:0] ain,
  input  logic [MulW-1:0] bin,
  output logic            busy,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [MulW-1:0] product
);

  state_e               state_q, state_d;
  logic [MulW-1:0]      acc_q, acc_d;
  logic [MulW-1:0]      mcand_q, mcand_d;
  logic [MulW-1:0]      mplier_q, mplier_d;
  logic [MulCntW-1:0]   cnt_q, cnt_d;
  logic [MulW-1:0]      add_sum;
  logic                 unused_cout;

  cla_adder_16bit u_adder (
    .ain  (acc_q),
    .bin  (mcand_q),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (unused_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          mcand_d  = ain;
          mplier_d = bin;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        acc_d    = mplier_q[0] ? add_sum : acc_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        // Early exit once no set multiplier bits remain to be added.
        if ((cnt_q == '1) || (EARLY_TERM && (mplier_d == '0))) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (res_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q == StRun);
  assign res_valid = (state_q == StDone);
  assign product   = acc_q;

endmodule

// File: tb/tb_seq_mul_16bit.sv
// Scoreboard bench for seq_mul_16bit: fixed-latency and early-terminating instances side by side.
module tb_seq_mul_16bit;

  typedef struct {
    logic [15:0] prod;
    int          lat;
    int          acc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        iv0, iv1, ir0, ir1, busy0, busy1, rv0, rv1, rr0, rr1;
  logic [15:0] a0, a1, b0, b1, p0, p1;

  exp_t q0[$];
  exp_t q1[$];
  bit   seen0, seen1;
  int   cyc;
  int   n_checks;
  int   n_fail;

  seq_mul_16bit #(.EARLY_TERM(1'b0)) u_dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv0),
    .in_ready  (ir0),
    .ain       (a0),
    .bin       (b0),
    .busy      (busy0),
    .res_valid (rv0),
    .res_ready (rr0),
    .product   (p0)
  );

  seq_mul_16bit #(.EARLY_TERM(1'b1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv1),
    .in_ready  (ir1),
    .ain       (a1),
    .bin       (b1),
    .busy      (busy1),
    .res_valid (rv1),
    .res_ready (rr1),
    .product   (p1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitors: product/in_ready checked every DONE cycle, latency on DONE entry, pop on handshake.
  always @(negedge clk) begin
    if (rv0) begin
      if (q0.size() == 0) begin
        chk("dut0_unexpected_result", {31'd0, rv0}, 32'd0);
      end else begin
        if (!seen0) begin
          seen0 = 1'b1;
          chk("dut0_latency", cyc - q0[0].acc, q0[0].lat);
        end
        chk("dut0_product", {16'd0, p0}, {16'd0, q0[0].prod});
        chk("dut0_in_ready_in_done", {31'd0, ir0}, 32'd0);
        if (rr0) begin
          void'(q0.pop_front());
          seen0 = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rv1) begin
      if (q1.size() == 0) begin
        chk("dut1_unexpected_result", {31'd0, rv1}, 32'd0);
      end else begin
        if (!seen1) begin
          seen1 = 1'b1;
          chk("dut1_latency", cyc - q1[0].acc, q1[0].lat);
        end
        chk("dut1_product", {16'd0, p1}, {16'd0, q1[0].prod});
        chk("dut1_in_ready_in_done", {31'd0, ir1}, 32'd0);
        if (rr1) begin
          void'(q1.pop_front());
          seen1 = 1'b0;
        end
      end
    end
  end

  // Presents operands and holds in_valid until accepted; in_valid is left high on return.
  task automatic do_op(input bit which, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] prod, input int lat, output int acc_cyc);
    int   n;
    exp_t e;
    n = 0;
    if (which) begin
      iv1 = 1'b1; a1 = a; b1 = b;
      while (!ir1 && n < 100) begin step(); n++; end
      chk("dut1_accept_timeout", {31'd0, ir1}, 32'd1);
    end else begin
      iv0 = 1'b1; a0 = a; b0 = b;
      while (!ir0 && n < 100) begin step(); n++; end
      chk("dut0_accept_timeout", {31'd0, ir0}, 32'd1);
    end
    e.prod = prod;
    e.lat  = lat;
    e.acc  = cyc + 1;
    acc_cyc = cyc + 1;
    if (which) q1.push_back(e);
    else       q0.push_back(e);
    step();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin step(); n++; end
    chk("drain_timeout", q0.size() + q1.size(), 0);
  endtask

  task automatic wait_done0();
    int n;
    n = 0;
    while (!rv0 && n < 100) begin step(); n++; end
    chk("dut0_done_timeout", {31'd0, rv0}, 32'd1);
  endtask

  initial begin
    int t0, t1, t2, tmp;
    n_checks = 0;
    n_fail   = 0;
    seen0 = 1'b0; seen1 = 1'b0;
    rst_n = 1'b0;
    iv0 = 1'b0; iv1 = 1'b0; a0 = '0; a1 = '0; b0 = '0; b1 = '0;
    rr0 = 1'b1; rr1 = 1'b1;
    step(); step();
    chk("rst_in_ready",  {30'd0, ir0, ir1},     32'd3);
    chk("rst_busy",      {30'd0, busy0, busy1}, 32'd0);
    chk("rst_res_valid", {30'd0, rv0, rv1},     32'd0);
    chk("rst_product",   {p0, p1},              32'd0);
    rst_n = 1'b1;
    step();

    // Fixed latency and truncation
    do_op(1'b0, 16'h0003, 16'h0005, 16'h000F, 16, tmp); iv0 = 1'b0;
    drain();
    do_op(1'b0, 16'hFFFF, 16'hFFFF, 16'h0001, 16, tmp); iv0 = 1'b0;
    drain();
    do_op(1'b0, 16'h1234, 16'h0100, 16'h3400, 16, tmp); iv0 = 1'b0;
    drain();

    // Result back-pressure; in_valid during DONE must be ignored
    rr0 = 1'b0;
    do_op(1'b0, 16'h0013, 16'h0011, 16'h0143, 16, tmp); iv0 = 1'b0;
    wait_done0();
    iv0 = 1'b1; a0 = 16'h5555; b0 = 16'h0002;
    repeat (5) step();
    iv0 = 1'b0;
    rr0 = 1'b1;
    step();
    chk("done_release_in_ready",  {31'd0, ir0}, 32'd1);
    chk("done_release_res_valid", {31'd0, rv0}, 32'd0);
    step();
    chk("idle_holds_busy", {31'd0, busy0}, 32'd0);
    chk("idle_holds_ready", {31'd0, ir0}, 32'd1);
    drain();

    // Reset at RUN step 7
    do_op(1'b0, 16'h00FF, 16'h00FF, 16'hFE01, 16, tmp); iv0 = 1'b0;
    repeat (7) step();
    chk("pre_reset_busy", {31'd0, busy0}, 32'd1);
    rst_n = 1'b0;
    q0.delete();
    seen0 = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_reset_in_ready",  {31'd0, ir0}, 32'd1);
    chk("mid_reset_busy",      {31'd0, busy0}, 32'd0);
    chk("mid_reset_res_valid", {31'd0, rv0}, 32'd0);
    chk("mid_reset_product",   {16'd0, p0}, 32'd0);
    do_op(1'b0, 16'h1111, 16'h0003, 16'h3333, 16, tmp); iv0 = 1'b0;
    drain();

    // Early termination
    do_op(1'b1, 16'h0010, 16'h0003, 16'h0030, 2, tmp); iv1 = 1'b0;
    drain();
    do_op(1'b1, 16'hBEEF, 16'h0000, 16'h0000, 1, tmp); iv1 = 1'b0;
    drain();
    do_op(1'b1, 16'h0101, 16'h0005, 16'h0505, 3, tmp); iv1 = 1'b0;
    drain();
    do_op(1'b1, 16'h0003, 16'h8000, 16'h8000, 16, tmp); iv1 = 1'b0;
    drain();

    // Back-to-back with in_valid held high
    do_op(1'b0, 16'h0007, 16'h0009, 16'h003F, 16, t0);
    do_op(1'b0, 16'h8000, 16'h0002, 16'h0000, 16, t1);
    do_op(1'b0, 16'hABCD, 16'h0001, 16'hABCD, 16, t2);
    iv0 = 1'b0;
    chk("b2b_spacing_1", t1 - t0, 18);
    chk("b2b_spacing_2", t2 - t1, 18);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
